// File: rtl/multi_cycle_pkg.sv
// Shared types and encodings for the multi-cycle RISC-V control unit.
// RV32I base opcodes live here alongside the datapath select encodings.
package multi_cycle_pkg;

  typedef enum logic [2:0] {
    S_IF,
    S_ID,
    S_EX,
    S_MEM,
    S_WB,
    S_BR_TAKEN,
    S_HALT
  } state_t;

  localparam logic [1:0] SRC_A_PC     = 2'd0;
  localparam logic [1:0] SRC_A_OLD_PC = 2'd1;
  localparam logic [1:0] SRC_A_REG    = 2'd2;

  localparam logic [1:0] SRC_B_REG    = 2'd0;
  localparam logic [1:0] SRC_B_IMM    = 2'd1;
  localparam logic [1:0] SRC_B_FOUR   = 2'd2;

  localparam logic [1:0] ALU_OP_ADD    = 2'd0;
  localparam logic [1:0] ALU_OP_BRANCH = 2'd1;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MDR = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  localparam logic [6:0] OP_ARITHMETIC     = 7'b0110011;
  localparam logic [6:0] OP_ARITHMETIC_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD           = 7'b0000011;
  localparam logic [6:0] OP_STORE          = 7'b0100011;
  localparam logic [6:0] OP_BRANCH         = 7'b1100011;
  localparam logic [6:0] OP_JAL            = 7'b1101111;
  localparam logic [6:0] OP_JALR           = 7'b1100111;
  localparam logic [6:0] OP_ECALL          = 7'b1110011;

  // Opcodes that proceed from ID into EX; ECALL is handled in ID itself.
  function automatic logic is_exec_opcode(input logic [6:0] op);
    case (op)
      OP_ARITHMETIC, OP_ARITHMETIC_IMM, OP_LOAD, OP_STORE,
      OP_BRANCH, OP_JAL, OP_JALR: is_exec_opcode = 1'b1;
      default:                    is_exec_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Access-cycle counter for IF and MEM; last flags the final cycle of an access.
module mem_wait_counter #(
  parameter int MEM_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam int W = $clog2(MEM_LATENCY + 1);
  localparam logic [W-1:0] LAST_VAL = W'(MEM_LATENCY - 1);
  localparam logic [W-1:0] ONE      = W'(1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + ONE;
    end
  end

  assign last = (count == LAST_VAL);

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle sequencer: steps each instruction through IF/ID/EX/MEM/WB and
// drives every datapath enable and mux select.
//
// state      | meaning
// S_IF       | fetch, held MEM_LATENCY cycles; IR and PC+4 latched on the last
// S_ID       | decode; ECALL and unknown opcodes resolve here
// S_EX       | ALU op by opcode; JAL/JALR finish here
// S_MEM      | load/store access, held MEM_LATENCY cycles
// S_WB       | register file write from ALUOut or MDR
// S_BR_TAKEN | PC <= OLD_PC + IMM
// S_HALT     | sticky halt until reset
module multi_cycle_control_unit
  import multi_cycle_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       alu_bcond,
  input  logic       halt_cond,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       mdr_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       is_halted
);

  state_t state, state_next;
  logic   wait_last;
  logic   wait_clear;
  logic   wait_enable;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IF;
    end else begin
      state <= state_next;
    end
  end

  // Counter resets whenever the state changes, so each access starts at 0.
  assign wait_clear  = (state_next != state);
  assign wait_enable = ((state == S_IF) || (state == S_MEM)) && !wait_last;

  mem_wait_counter #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_wait (
    .clk    (clk),
    .reset  (reset),
    .clear  (wait_clear),
    .enable (wait_enable),
    .last   (wait_last)
  );

  always_comb begin
    state_next = state;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    mdr_write  = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_REG;
    alu_op     = ALU_OP_ADD;
    reg_write  = 1'b0;
    wb_sel     = WB_ALU;
    is_halted  = 1'b0;

    case (state)
      S_IF: begin
        mem_read = 1'b1;
        if (wait_last) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          alu_src_a  = SRC_A_PC;
          alu_src_b  = SRC_B_FOUR;
          alu_op     = ALU_OP_ADD;
          state_next = S_ID;
        end
      end

      S_ID: begin
        if (opcode == OP_ECALL) begin
          state_next = halt_cond ? S_HALT : S_IF;
        end else if (is_exec_opcode(opcode)) begin
          state_next = S_EX;
        end else begin
          state_next = S_IF;
        end
      end

      S_EX: begin
        state_next = S_IF;
        case (opcode)
          OP_ARITHMETIC: begin
            alu_src_a  = SRC_A_REG;
            alu_src_b  = SRC_B_REG;
            alu_op     = ALU_OP_FUNCT;
            state_next = S_WB;
          end
          OP_ARITHMETIC_IMM: begin
            alu_src_a  = SRC_A_REG;
            alu_src_b  = SRC_B_IMM;
            alu_op     = ALU_OP_FUNCT;
            state_next = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a  = SRC_A_REG;
            alu_src_b  = SRC_B_IMM;
            alu_op     = ALU_OP_ADD;
            state_next = S_MEM;
          end
          OP_BRANCH: begin
            alu_src_a  = SRC_A_REG;
            alu_src_b  = SRC_B_REG;
            alu_op     = ALU_OP_BRANCH;
            state_next = alu_bcond ? S_BR_TAKEN : S_IF;
          end
          OP_JAL, OP_JALR: begin
            alu_src_a = (opcode == OP_JAL) ? SRC_A_OLD_PC : SRC_A_REG;
            alu_src_b = SRC_B_IMM;
            alu_op    = ALU_OP_ADD;
            pc_write  = 1'b1;
            reg_write = 1'b1;
            wb_sel    = WB_PC;
          end
          default: state_next = S_IF;
        endcase
      end

      S_MEM: begin
        i_or_d = 1'b1;
        if (opcode == OP_LOAD) begin
          mem_read = 1'b1;
          if (wait_last) begin
            mdr_write  = 1'b1;
            state_next = S_WB;
          end
        end else if (opcode == OP_STORE) begin
          mem_write = 1'b1;
          if (wait_last) begin
            state_next = S_IF;
          end
        end else begin
          state_next = S_IF;
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        wb_sel     = (opcode == OP_LOAD) ? WB_MDR : WB_ALU;
        state_next = S_IF;
      end

      S_BR_TAKEN: begin
        alu_src_a  = SRC_A_OLD_PC;
        alu_src_b  = SRC_B_IMM;
        alu_op     = ALU_OP_ADD;
        pc_write   = 1'b1;
        state_next = S_IF;
      end

      S_HALT: begin
        is_halted  = 1'b1;
        state_next = S_HALT;
      end

      default: state_next = S_IF;
    endcase

    // Reset masks every output, including the fetch read.
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      i_or_d    = 1'b0;
      mdr_write = 1'b0;
      alu_src_a = 2'd0;
      alu_src_b = 2'd0;
      alu_op    = 2'd0;
      reg_write = 1'b0;
      wb_sel    = 2'd0;
      is_halted = 1'b0;
    end
  end

endmodule
